vram_arb: RTL and testbench

Framebuffer port scheduler for the VGA game display path. It shares one single-port, synchronous-read video RAM between two users. The display scan, driven by the `hen`/`ven` outputs of the sync timing generator, gets every active-region cycle. Game-logic writers share all blanking cycles round-robin. It also produces the pixel fetch addresses for a downscaled framebuffer, returns pixel data with delay-matched sync signals, and emits a vblank pulse for frame-rate game updates.

---
 rtl/du_pkg.sv | 29 ++
 rtl/vram_arb_if.sv | 27 ++
 rtl/rr_arb.sv | 32 +++
 rtl/vram_arb.sv | 159 +++++++++++++++
 tb/tb_vram_arb.sv | 191 +++++++++++++++++++
 5 files changed

// File: rtl/du_pkg.sv
// Shared definitions for the display path: phase encoding, default geometry
// and the pixel pipeline depth.
package du_pkg;

    typedef enum logic [1:0] {
        VBLANK = 2'd0,
        LINE   = 2'd1,
        HBLANK = 2'd2
    } phase_t;

    localparam int H_PIX_DEF      = 200;
    localparam int V_PIX_DEF      = 150;
    localparam int SCALE_LOG2_DEF = 2;
    localparam int DW_DEF         = 12;
    localparam int DISP_LAT       = 2;

    typedef struct packed {
        logic hs;
        logic vs;
        logic hen;
        logic disp;
    } sync_t;

    // Index width that stays at least one bit for a single requester.
    function automatic int idx_w(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/vram_arb_if.sv
// Writer handshake and video RAM port bundle. The arbiter is the slave of the
// writers and drives the RAM port.
interface vram_arb_if #(
    parameter int N_REQ = 2,
    parameter int AW    = 15,
    parameter int DW    = 12
);
    logic [N_REQ-1:0]    wr_req;
    logic [N_REQ*AW-1:0] wr_addr;
    logic [N_REQ*DW-1:0] wr_data;
    logic [N_REQ-1:0]    wr_gnt;
    logic                wr_err;
    logic [AW-1:0]       ram_addr;
    logic                ram_we;
    logic [DW-1:0]       ram_wdata;
    logic [DW-1:0]       ram_rdata;

    modport slave (
        input  wr_req, wr_addr, wr_data, ram_rdata,
        output wr_gnt, wr_err, ram_addr, ram_we, ram_wdata
    );

    modport master (
        output wr_req, wr_addr, wr_data, ram_rdata,
        input  wr_gnt, wr_err, ram_addr, ram_we, ram_wdata
    );
endinterface

// File: rtl/rr_arb.sv
// Combinational round-robin picker: first asserted request at or after i_ptr,
// wrapping around the request vector.
module rr_arb #(
    parameter int N  = 2,
    parameter int IW = du_pkg::idx_w(N)
) (
    input  logic [N-1:0]  i_req,
    input  logic [IW-1:0] i_ptr,
    output logic [N-1:0]  o_gnt,
    output logic [IW-1:0] o_idx,
    output logic          o_any
);
    int w_k;

    // Scan from the farthest offset down so the nearest request wins last.
    always_comb begin
        o_gnt = '0;
        o_idx = '0;
        o_any = 1'b0;
        w_k   = 0;
        for (int off = N - 1; off >= 0; off--) begin
            w_k = (int'(i_ptr) + off) % N;
            if (i_req[w_k]) begin
                o_gnt      = '0;
                o_gnt[w_k] = 1'b1;
                o_idx      = IW'(w_k);
                o_any      = 1'b1;
            end
        end
    end

endmodule

// File: rtl/vram_arb.sv
// Video RAM port scheduler: display scan owns active cycles, writers share
// blanking round-robin; also generates scan addresses and the pixel pipeline.
module vram_arb
    import du_pkg::*;
#(
    parameter int N_REQ      = 2,
    parameter int H_PIX      = H_PIX_DEF,
    parameter int V_PIX      = V_PIX_DEF,
    parameter int SCALE_LOG2 = SCALE_LOG2_DEF,
    parameter int AW         = 15,
    parameter int DW         = DW_DEF
) (
    input  logic          clk_px,
    input  logic          rst_n,
    input  logic          hen,
    input  logic          ven,
    input  logic          hs,
    input  logic          vs,
    vram_arb_if.slave     bus,
    output logic [DW-1:0] rgb,
    output logic          hs_o,
    output logic          vs_o,
    output logic          hen_o,
    output logic          vblank_p
);
    localparam int             IW     = idx_w(N_REQ);
    localparam int             SW     = (SCALE_LOG2 > 0) ? SCALE_LOG2 : 1;
    localparam logic [SW-1:0]  SMAX   = SW'((1 << SCALE_LOG2) - 1);
    localparam logic [AW:0]    FB_LIM = (AW + 1)'(H_PIX * V_PIX);

    logic [IW-1:0] r_rr_ptr;
    logic [AW-1:0] r_last_addr;
    logic [SW-1:0] r_sub_x;
    logic [SW-1:0] r_sub_y;
    logic [AW-1:0] r_col;
    logic [AW-1:0] r_row_base;
    logic          r_hen_d;
    logic          r_ven_d;
    logic [DW-1:0] r_rgb;
    phase_t        r_phase;

    logic             w_disp;
    logic             w_slot;
    logic             w_grant;
    logic             w_any;
    logic [N_REQ-1:0] w_pick;
    logic [IW-1:0]    w_idx;
    logic [AW-1:0]    w_sel_addr;
    logic [DW-1:0]    w_sel_data;
    logic             w_in_range;
    logic [AW-1:0]    w_scan;
    sync_t            w_tap [0:DISP_LAT];

    assign w_disp = hen & ven;
    // Reset gates the combinational outputs so they clear without a clock.
    assign w_slot = ~w_disp & rst_n;

    rr_arb #(.N(N_REQ), .IW(IW)) u_rr_arb (
        .i_req (bus.wr_req),
        .i_ptr (r_rr_ptr),
        .o_gnt (w_pick),
        .o_idx (w_idx),
        .o_any (w_any)
    );

    assign w_grant    = w_slot & w_any;
    assign w_sel_addr = bus.wr_addr[w_idx*AW +: AW];
    assign w_sel_data = bus.wr_data[w_idx*DW +: DW];
    assign w_in_range = {1'b0, w_sel_addr} < FB_LIM;
    assign w_scan     = r_row_base + r_col;

    assign bus.wr_gnt    = w_grant ? w_pick : '0;
    assign bus.wr_err    = w_grant & ~w_in_range;
    assign bus.ram_we    = w_grant & w_in_range;
    assign bus.ram_wdata = w_grant ? w_sel_data : '0;
    assign bus.ram_addr  = !rst_n  ? '0 :
                           w_disp  ? w_scan :
                           w_grant ? w_sel_addr : r_last_addr;

    assign vblank_p = rst_n & r_ven_d & ~ven;

    always_ff @(posedge clk_px or negedge rst_n) begin
        if (!rst_n) begin
            r_rr_ptr    <= '0;
            r_last_addr <= '0;
            r_sub_x     <= '0;
            r_sub_y     <= '0;
            r_col       <= '0;
            r_row_base  <= '0;
            r_hen_d     <= 1'b0;
            r_ven_d     <= 1'b0;
            r_rgb       <= '0;
        end else begin
            r_last_addr <= bus.ram_addr;
            r_hen_d     <= hen;
            r_ven_d     <= ven;
            r_rgb       <= bus.ram_rdata;
            if (w_grant) begin
                r_rr_ptr <= (w_idx == IW'(N_REQ - 1)) ? '0 : w_idx + IW'(1);
            end
            if (!hen) begin
                r_sub_x <= '0;
                r_col   <= '0;
            end else if (w_disp) begin
                if (r_sub_x == SMAX) begin
                    r_sub_x <= '0;
                    r_col   <= r_col + AW'(1);
                end else begin
                    r_sub_x <= r_sub_x + SW'(1);
                end
            end
            // A framebuffer row spans 2^SCALE_LOG2 screen lines.
            if (!ven) begin
                r_sub_y    <= '0;
                r_row_base <= '0;
            end else if (r_hen_d && !hen) begin
                if (r_sub_y == SMAX) begin
                    r_sub_y    <= '0;
                    r_row_base <= r_row_base + AW'(H_PIX);
                end else begin
                    r_sub_y <= r_sub_y + SW'(1);
                end
            end
        end
    end

    always_ff @(posedge clk_px or negedge rst_n) begin
        if (!rst_n) begin
            r_phase <= VBLANK;
        end else begin
            case (r_phase)
                VBLANK:  if (ven && hen) r_phase <= LINE;
                LINE:    if (!ven) r_phase <= VBLANK; else if (!hen) r_phase <= HBLANK;
                HBLANK:  if (!ven) r_phase <= VBLANK; else if (hen) r_phase <= LINE;
                default: r_phase <= VBLANK;
            endcase
        end
    end

    assign w_tap[0] = '{hs: hs, vs: vs, hen: hen, disp: w_disp};

    genvar gi;
    generate
        for (gi = 0; gi < DISP_LAT; gi++) begin : g_dly
            sync_t r_stage;
            always_ff @(posedge clk_px or negedge rst_n) begin
                if (!rst_n) r_stage <= '0;
                else        r_stage <= w_tap[gi];
            end
            assign w_tap[gi+1] = r_stage;
        end
    endgenerate

    assign hs_o  = w_tap[DISP_LAT].hs;
    assign vs_o  = w_tap[DISP_LAT].vs;
    assign hen_o = w_tap[DISP_LAT].hen;
    assign rgb   = w_tap[DISP_LAT].disp ? r_rgb : '0;

endmodule

// File: tb/tb_vram_arb.sv
// Directed bench for vram_arb with a behavioural synchronous-read RAM.
module tb_vram_arb;
    logic        clk_px = 1'b0;
    logic        rst_n;
    logic        hen, ven, hs, vs;
    logic [11:0] rgb;
    logic        hs_o, vs_o, hen_o, vblank_p;
    logic [11:0] mem [0:32767];
    int          n_checks = 0;
    int          n_pass   = 0;

    vram_arb_if #(.N_REQ(2), .AW(15), .DW(12)) bus ();

    vram_arb dut (
        .clk_px   (clk_px),
        .rst_n    (rst_n),
        .hen      (hen),
        .ven      (ven),
        .hs       (hs),
        .vs       (vs),
        .bus      (bus),
        .rgb      (rgb),
        .hs_o     (hs_o),
        .vs_o     (vs_o),
        .hen_o    (hen_o),
        .vblank_p (vblank_p)
    );

    always #5 clk_px = ~clk_px;

    always @(posedge clk_px) begin
        if (bus.ram_we) mem[bus.ram_addr] <= bus.ram_wdata;
        bus.ram_rdata <= mem[bus.ram_addr];
    end

    always @(negedge clk_px) begin
        if (|bus.wr_gnt)
            $display("write gnt=%b addr=%0d data=%h we=%b err=%b",
                     bus.wr_gnt, bus.ram_addr, bus.ram_wdata, bus.ram_we, bus.wr_err);
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs === exp) n_pass++;
        else $display("FAIL %s: got %0h want %0h", tag, obs, exp);
    endtask

    task automatic tick();
        @(posedge clk_px);
        #1;
    endtask

    task automatic short_line();
        hen = 1'b1; tick();
        hen = 1'b0; tick();
    endtask

    initial begin
        mem[0] = 12'hABC;
        rst_n = 1'b0; hen = 1'b0; ven = 1'b0; hs = 1'b1; vs = 1'b1;
        bus.wr_req  = 2'b11;
        bus.wr_addr = {15'd20, 15'd10};
        bus.wr_data = {12'h222, 12'h111};
        repeat (3) @(posedge clk_px);
        #1;
        check("rst_gnt",    bus.wr_gnt,   0);
        check("rst_err",    bus.wr_err,   0);
        check("rst_we",     bus.ram_we,   0);
        check("rst_addr",   bus.ram_addr, 0);
        check("rst_rgb",    rgb,          0);
        check("rst_hs_o",   hs_o,         0);
        check("rst_vs_o",   vs_o,         0);
        check("rst_hen_o",  hen_o,        0);
        check("rst_vblank", vblank_p,     0);

        rst_n = 1'b1; hs = 1'b0; vs = 1'b0;
        bus.wr_req  = 2'b10;
        bus.wr_addr = {15'd30000, 15'd10};
        #2;
        check("oor_gnt",  bus.wr_gnt,   2'b10);
        check("oor_err",  bus.wr_err,   1);
        check("oor_we",   bus.ram_we,   0);
        check("oor_addr", bus.ram_addr, 30000);
        tick();

        bus.wr_req  = 2'b11;
        bus.wr_addr = {15'd20, 15'd10};
        #2;
        check("rr0_gnt",  bus.wr_gnt,    2'b01);
        check("rr0_addr", bus.ram_addr,  10);
        check("rr0_we",   bus.ram_we,    1);
        check("rr0_data", bus.ram_wdata, 12'h111);
        tick(); #2;
        check("rr1_gnt",  bus.wr_gnt,    2'b10);
        check("rr1_addr", bus.ram_addr,  20);
        check("rr1_data", bus.ram_wdata, 12'h222);
        tick(); #2;
        check("rr2_gnt",  bus.wr_gnt,    2'b01);
        tick();
        bus.wr_req = 2'b00; #2;
        check("idle_gnt",  bus.wr_gnt,   0);
        check("idle_we",   bus.ram_we,   0);
        check("idle_hold", bus.ram_addr, 10);
        tick();

        ven = 1'b1; hen = 1'b1;
        bus.wr_req  = 2'b01;
        bus.wr_addr = {15'd20, 15'd5};
        bus.wr_data = {12'h222, 12'hF00};
        for (int c = 0; c < 800; c++) begin
            #2;
            check("scan0", bus.ram_addr, c >> 2);
            if (c == 0 || c == 799) begin
                check("disp_gnt", bus.wr_gnt, 0);
                check("disp_we",  bus.ram_we, 0);
            end
            if (c == 1) begin
                check("pre_rgb",   rgb,   0);
                check("pre_hen_o", hen_o, 0);
            end
            if (c == 2) begin
                check("rd_rgb",   rgb,   12'hABC);
                check("rd_hen_o", hen_o, 1);
            end
            tick();
        end
        hen = 1'b0; #2;
        check("col_gnt",   bus.wr_gnt,    2'b01);
        check("col_we",    bus.ram_we,    1);
        check("col_addr",  bus.ram_addr,  5);
        check("col_data",  bus.ram_wdata, 12'hF00);
        check("hb_vblank", vblank_p,      0);
        tick();
        bus.wr_req = 2'b00; #2;
        check("mem5",     mem[5], 12'hF00);
        check("hen_o_d1", hen_o,  1);
        tick(); #2;
        check("hen_o_d2", hen_o,  0);
        check("rgb_hb",   rgb,    0);
        tick();

        for (int l = 1; l < 4; l++) short_line();
        hen = 1'b1;
        for (int c = 0; c < 5; c++) begin
            #2;
            if (c == 0) check("line4_first", bus.ram_addr, 200);
            if (c == 4) check("line4_c4",    bus.ram_addr, 201);
            tick();
        end
        hen = 1'b0; tick();
        for (int l = 5; l < 599; l++) short_line();

        hen = 1'b1;
        for (int c = 0; c < 800; c++) begin
            #2;
            if (c == 0)   check("last_first", bus.ram_addr, 29800);
            if (c == 799) check("last_final", bus.ram_addr, 29999);
            tick();
        end
        hen = 1'b0; tick();
        ven = 1'b0; #2;
        check("vblank_hi", vblank_p, 1);
        tick(); #2;
        check("vblank_lo", vblank_p, 0);
        tick();

        ven = 1'b1; hen = 1'b1; #2;
        check("frame_addr0", bus.ram_addr, 0);
        tick(); tick(); #2;
        check("frame_rgb",   rgb,   12'hABC);
        check("frame_hen_o", hen_o, 1);

        hen = 1'b0;
        bus.wr_req = 2'b01;
        #1 rst_n = 1'b0;
        #1;
        check("arst_rgb",   rgb,          0);
        check("arst_hen_o", hen_o,        0);
        check("arst_gnt",   bus.wr_gnt,   0);
        check("arst_we",    bus.ram_we,   0);
        check("arst_addr",  bus.ram_addr, 0);
        tick();
        rst_n = 1'b1;
        bus.wr_req = 2'b00;
        tick();

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
